// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the oversampling UART receiver: FSM states, parity modes,
// error-flag bit positions and oversample tick indices.
package uart_rx_fifo_pkg;

    localparam int OVS     = 16;
    localparam int TICK_W  = $clog2(OVS);
    localparam int TICK_S0 = 7;
    localparam int TICK_S1 = 8;
    localparam int TICK_S2 = 9;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int ERR_FRAME  = 0;
    localparam int ERR_PARITY = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// First-word-fall-through register FIFO; head entry is presented while not empty.
module uart_rx_fifo_buf #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 3-sample majority vote, parity/framing/break
// detection, feeding a FWFT receive FIFO.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int CLK_DIV    = 27,
    parameter  int DATA_BITS  = 8,
    parameter  int PARITY     = 0,
    parameter  int STOP_BITS  = 1,
    parameter  int FIFO_DEPTH = 16,
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic [1:0]           rd_err,
    output logic                 empty,
    output logic                 full,
    output logic [FIFO_AW:0]     count,
    output logic                 rx_busy,
    output logic                 rx_end,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic                 break_det
);
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    state_t                state, state_nx;
    logic                  rx_meta, rx_sync, rx_prev;
    logic [15:0]           div_cnt;
    logic [TICK_W-1:0]     tick_idx;
    logic                  tick, bit_strobe, bit_val, start_det;
    logic [1:0]            smp;
    logic [DATA_BITS-1:0]  shreg;
    logic [2:0]            bit_cnt;
    logic                  stop_cnt, par_bit, ferr;
    logic                  shift_en, par_en, stop_en, done, brk;
    logic                  par_calc;
    logic [1:0]            err_now;
    logic [DATA_BITS+1:0]  fifo_rdata;

    assign tick       = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign bit_strobe = tick && (tick_idx == TICK_W'(TICK_S2));
    assign bit_val    = maj3(smp[0], smp[1], rx_sync);
    assign start_det  = (state == S_IDLE) && rx_prev && !rx_sync;
    assign rx_busy    = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        done     = 1'b0;
        brk      = 1'b0;
        unique case (state)
            S_IDLE:  if (start_det) state_nx = S_START;
            S_START: if (bit_strobe) state_nx = bit_val ? S_IDLE : S_DATA;
            S_DATA: if (bit_strobe) begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_BIT) state_nx = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_strobe) begin
                par_en   = 1'b1;
                state_nx = S_STOP;
            end
            S_STOP: if (bit_strobe) begin
                // Line held low through data, parity and first stop sample is a break, not a char.
                if (!stop_cnt && !bit_val && (shreg == '0) && !par_bit) begin
                    brk      = 1'b1;
                    state_nx = S_WAIT_IDLE;
                end else begin
                    stop_en = 1'b1;
                    if (stop_cnt == LAST_STOP) begin
                        done     = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: if (rx_sync) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            div_cnt   <= '0;
            tick_idx  <= '0;
            smp       <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_bit   <= 1'b0;
            ferr      <= 1'b0;
            rx_end    <= 1'b0;
            break_det <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            rx_end    <= done;
            break_det <= brk;

            if (state == S_IDLE) begin
                div_cnt  <= '0;
                tick_idx <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                tick_idx <= tick_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (tick && (tick_idx == TICK_W'(TICK_S0))) smp[0] <= rx_sync;
            if (tick && (tick_idx == TICK_W'(TICK_S1))) smp[1] <= rx_sync;

            if (start_det) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                par_bit  <= 1'b0;
                ferr     <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_en) par_bit <= bit_val;
            if (stop_en) begin
                stop_cnt <= stop_cnt + 1'b1;
                if (!bit_val) ferr <= 1'b1;
            end

            // A drop in the same cycle as the clear keeps the flag set.
            if (rx_end && full && !rd_en) overrun <= 1'b1;
            else if (ovr_clr)             overrun <= 1'b0;
        end
    end

    always_comb begin
        par_calc            = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
        err_now             = '0;
        err_now[ERR_PARITY] = (PARITY != PAR_NONE) && (par_bit != par_calc);
        err_now[ERR_FRAME]  = ferr;
    end

    uart_rx_fifo_buf #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (rx_end),
        .pop   (rd_en),
        .wdata ({err_now, shreg}),
        .rdata (fifo_rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign rd_data = fifo_rdata[DATA_BITS-1:0];
    assign rd_err  = fifo_rdata[DATA_BITS+1:DATA_BITS];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (8 data bits, even parity, 1 stop, 4-entry FIFO, 32 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CLKS   = CLK_DIV * 16;

    logic       clk = 1'b0, reset = 1'b0, rx = 1'b1, rd_en = 1'b0, ovr_clr = 1'b0;
    logic [7:0] rd_data;
    logic [1:0] rd_err;
    logic [2:0] count;
    logic       empty, full, rx_busy, rx_end, overrun, break_det;

    int         checks = 0, errors = 0;
    int         n_end = 0, n_brk = 0, exp_end = 0, exp_brk = 0;
    logic       exp_ovr = 1'b0;
    bit         reader_on = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_item;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
        .empty(empty), .full(full), .count(count), .rx_busy(rx_busy), .rx_end(rx_end),
        .overrun(overrun), .ovr_clr(ovr_clr), .break_det(break_det)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Monitor: pops the head whenever data is present and compares it with the scoreboard.
    initial forever begin
        @(negedge clk);
        rd_en = 1'b0;
        if (reset) begin
            if (rx_end)    n_end++;
            if (break_det) n_brk++;
            if (reader_on && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected entry: got err=%b data=0x%0h, none expected", rd_err, rd_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("head entry {err,data}", int'({rd_err, rd_data}), int'(exp_item));
                end
                rd_en = 1'b1;
            end
        end
    end

    task automatic bit_time(input logic v, input logic glitch);
        rx = v;
        if (glitch) begin
            repeat (16) @(negedge clk);
            rx = ~v;
            @(negedge clk);
            rx = v;
            repeat (BIT_CLKS - 17) @(negedge clk);
        end else begin
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    // Model: even parity, a frame is a break when data, parity and stop are all zero;
    // otherwise the char is stored if the FIFO has room, else overrun is expected.
    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_v,
                              input logic glitch);
        logic pbit, brk;
        pbit = (^d) ^ par_bad;
        brk  = (d == 8'h00) && !pbit && !stop_v;
        bit_time(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i], glitch);
        bit_time(pbit, 1'b0);
        if (brk) begin
            exp_brk++;
        end else begin
            exp_end++;
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({par_bad, !stop_v, d});
            else exp_ovr = 1'b1;
        end
        bit_time(stop_v, 1'b0);
        if (!brk) begin
            rx = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        reader_on = 1'b1;
        while ((exp_q.size() != 0 || !empty) && n < 400) begin
            @(negedge clk);
            n++;
        end
        step(2);
        check({name, " scoreboard left"}, exp_q.size(), 0);
        check({name, " empty"}, int'(empty), 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       pb, sv, gl;

        step(5);
        check("reset empty", int'(empty), 1);
        check("reset full", int'(full), 0);
        check("reset count", int'(count), 0);
        check("reset rx_busy", int'(rx_busy), 0);
        check("reset rx_end", int'(rx_end), 0);
        check("reset overrun", int'(overrun), 0);
        check("reset break_det", int'(break_det), 0);
        check("reset rd_data", int'(rd_data), 0);
        check("reset rd_err", int'(rd_err), 0);
        reset = 1'b1;
        step(5);

        // Two clean chars held in the FIFO, then popped in order.
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b0, 1'b1, 1'b0);
        step(2);
        check("two chars count", int'(count), 2);
        check("two chars head data", int'(rd_data), 'h55);
        check("two chars head err", int'(rd_err), 0);
        check("two chars rx_end pulses", n_end, exp_end);
        drain("two chars");

        // Parity error, then frame error kept while a break arrives.
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        drain("parity");
        reader_on = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        step(64);
        check("break pulses", n_brk, exp_brk);
        check("break busy while low", int'(rx_busy), 1);
        check("break count unchanged", int'(count), 1);
        check("break no rx_end", n_end, exp_end);
        rx = 1'b1;
        step(40);
        check("break released busy", int'(rx_busy), 0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        drain("after break");

        // False start: short low pulse.
        rx = 1'b0;
        step(6);
        check("false start busy", int'(rx_busy), 1);
        rx = 1'b1;
        step(60);
        check("false start idle", int'(rx_busy), 0);
        check("false start no rx_end", n_end, exp_end);
        send_frame(8'hC6, 1'b0, 1'b1, 1'b1);
        drain("glitch");

        // Overrun with no reads.
        reader_on = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(8'($urandom_range(1, 255)), 1'b0, 1'b1, 1'b0);
        step(2);
        check("ovr full", int'(full), 1);
        check("ovr count", int'(count), FIFO_DEPTH);
        check("ovr overrun", int'(overrun), int'(exp_ovr));
        check("ovr rx_end pulses", n_end, exp_end);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        step(1);
        check("ovr cleared", int'(overrun), int'(exp_ovr));
        drain("overrun");

        // Random characters with random parity/stop errors and glitches.
        reader_on = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d  = 8'($urandom_range(0, 255));
            pb = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 5) != 0) || (d == 8'h00);
            gl = 1'($urandom_range(0, 1));
            send_frame(d, pb, sv, gl);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        drain("random");
        check("random rx_end pulses", n_end, exp_end);
        check("random breaks", n_brk, exp_brk);
        check("random overrun", int'(overrun), 0);

        // Reset in the middle of a character.
        bit_time(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) bit_time(1'($urandom_range(0, 1)), 1'b0);
        rx = 1'b0;
        step(8);
        check("pre-reset busy", int'(rx_busy), 1);
        reset = 1'b0;
        step(2);
        check("mid reset busy", int'(rx_busy), 0);
        check("mid reset empty", int'(empty), 1);
        check("mid reset count", int'(count), 0);
        check("mid reset rx_end", int'(rx_end), 0);
        check("mid reset overrun", int'(overrun), 0);
        check("mid reset rd_data", int'(rd_data), 0);
        rx = 1'b1;
        step(2);
        reset = 1'b1;
        step(40);
        check("mid reset no rx_end", n_end, exp_end);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        drain("after reset");
        check("final rx_end pulses", n_end, exp_end);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
